// File: rtl/accumulator_controller.sv
// Accumulator controller: sequences ACCUM (tile write / read-modify-write) and DRAIN (tile readout) commands.
// Optional feature macro ACC_CTRL_DIAG_DRAIN_EN: diagonal-mode drain with 31 extra rows to flush the column skew.

package Acc_types;
    typedef enum logic {
        NORMAL   = 1'b0,
        DIAGONAL = 1'b1
    } acc_rd_mode;
endpackage

module accumulator_controller #(
    parameter int DEPTH = 128
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     op_i,
    input  logic                     overwrite_i,
    input  logic [$clog2(DEPTH)-1:0] base_addr_i,
    input  logic [$clog2(DEPTH)-1:0] num_rows_i,
    input  logic                     mmu_valid_i,
    input  logic                     out_ready_i,
    output logic                     port1_rd_en_o,
    output logic                     port2_wr_en_o,
    output logic                     add_o,
    output Acc_types::acc_rd_mode    rd_mode_o,
    output logic [$clog2(DEPTH)-1:0] addr_rd_o,
    output logic [$clog2(DEPTH)-1:0] addr_wr_o,
    output logic                     out_valid_o,
    output logic                     busy_o,
    output logic                     done_o
);
    import Acc_types::*;

    localparam int AW   = $clog2(DEPTH);
    localparam int SKEW = 31;
    localparam int CW   = $clog2(DEPTH + SKEW + 1);

`ifdef ACC_CTRL_DIAG_DRAIN_EN
    localparam acc_rd_mode DRAIN_MODE  = DIAGONAL;
    localparam int         DRAIN_EXTRA = SKEW;
`else
    localparam acc_rd_mode DRAIN_MODE  = NORMAL;
    localparam int         DRAIN_EXTRA = 0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_op;
    logic            r_overwrite;
    logic [AW-1:0]   r_base;
    logic [AW-1:0]   r_num_rows;
    logic [CW-1:0]   r_count;

    logic            w_accept;
    logic            w_advance;
    logic [CW-1:0]   w_rows;
    logic [CW-1:0]   w_last;
    logic [AW-1:0]   w_row_addr;

    // A row count of zero encodes a full DEPTH-row tile.
    assign w_rows     = (r_num_rows == '0) ? CW'(DEPTH) : CW'(r_num_rows);
    assign w_last     = (r_op ? (w_rows + CW'(DRAIN_EXTRA)) : w_rows) - CW'(1);
    assign w_row_addr = r_base + r_count[AW-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_op        <= 1'b0;
            r_overwrite <= 1'b0;
            r_base      <= '0;
            r_num_rows  <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op        <= op_i;
                r_overwrite <= overwrite_i;
                r_base      <= base_addr_i;
                r_num_rows  <= num_rows_i;
                r_count     <= '0;
            end else if (w_advance) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_advance     = 1'b0;
        port1_rd_en_o = 1'b0;
        port2_wr_en_o = 1'b0;
        add_o         = 1'b0;
        rd_mode_o     = NORMAL;
        addr_rd_o     = '0;
        addr_wr_o     = '0;
        out_valid_o   = 1'b0;
        done_o        = 1'b0;

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_accept     = 1'b1;
                    w_state_next = op_i ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (mmu_valid_i) begin
                    port2_wr_en_o = 1'b1;
                    addr_wr_o     = w_row_addr;
                    if (!r_overwrite) begin
                        port1_rd_en_o = 1'b1;
                        add_o         = 1'b1;
                        addr_rd_o     = w_row_addr;
                    end
                    w_advance = 1'b1;
                    if (r_count == w_last) w_state_next = DONE;
                end
            end
            DRAIN: begin
                port1_rd_en_o = 1'b1;
                rd_mode_o     = DRAIN_MODE;
                addr_rd_o     = w_row_addr;
                out_valid_o   = 1'b1;
                if (out_ready_i) begin
                    w_advance = 1'b1;
                    if (r_count == w_last) w_state_next = DONE;
                end
            end
            DONE: begin
                done_o       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign busy_o = (r_state != IDLE);

endmodule

// File: doc/accumulator_controller.md
ACCUMULATOR_CONTROLLER -- requirements
Module: accumulator_controller

Interface
REQ-001 Parameter DEPTH, default 128, number of accumulator rows; address width is $clog2(DEPTH).
REQ-002 Port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port rst_i, input, 1, asynchronous active-high reset.
REQ-004 Port start_i, input, 1, command request; accepted only in IDLE.
REQ-005 Port op_i, input, 1, command type: 0 = ACCUM (write a tile), 1 = DRAIN (read a tile out).
REQ-006 Port overwrite_i, input, 1, ACCUM only: 1 = store MMU data, 0 = add MMU data to stored rows.
REQ-007 Port base_addr_i, input, 7, first row of the command.
REQ-008 Port num_rows_i, input, 7, row count; value 0 means 128.
REQ-009 Port mmu_valid_i, input, 1, the MMU presents one result row this cycle.
REQ-010 Port out_ready_i, input, 1, the downstream buffer accepts a drained row this cycle.
REQ-011 Port port1_rd_en_o, output, 1, accumulator read enable.
REQ-012 Port port2_wr_en_o, output, 1, accumulator write enable.
REQ-013 Port add_o, output, 1, routes read data to the adder (1) or to data_o (0).
REQ-014 Port rd_mode_o, output, Acc_types::acc_rd_mode, read mode, NORMAL or diagonal.
REQ-015 Ports addr_rd_o and addr_wr_o, outputs, 7 each, read and write row addresses.
REQ-016 Port out_valid_o, output, 1, the accumulator data_o holds a valid drained row.
REQ-017 Ports busy_o and done_o, outputs, 1 each: busy_o = state not IDLE; done_o = one-cycle completion pulse.

Function
REQ-018 FSM states: IDLE, ACCUM, DRAIN, DONE.
REQ-019 IDLE with start_i=1 registers op_i, overwrite_i, base_addr_i and num_rows_i, clears the row counter, and moves to ACCUM (op_i=0) or DRAIN (op_i=1) on the next edge.
REQ-020 start_i outside IDLE shall be ignored without side effects.
REQ-021 ACCUM: in each cycle with mmu_valid_i=1, port2_wr_en_o=1 and addr_wr_o = (base + count) mod 128, combinationally from registered state; count increments on that edge.
REQ-022 ACCUM with overwrite=0: port1_rd_en_o=1, add_o=1, rd_mode_o=NORMAL and addr_rd_o=addr_wr_o in the same cycle as the write, giving a single-cycle read-modify-write.
REQ-023 ACCUM with overwrite=1: port1_rd_en_o=0 and add_o=0, so data_i is stored unmodified.
REQ-024 ACCUM cycles with mmu_valid_i=0 shall drive all enables to 0 and leave count unchanged.
REQ-025 DRAIN: port1_rd_en_o=1, add_o=0, port2_wr_en_o=0, addr_rd_o = (base + count) mod 128, out_valid_o=1; count advances only when out_ready_i=1.
REQ-026 With out_ready_i=0, all DRAIN outputs shall hold unchanged.
REQ-027 When the final row (count = num_rows-1) is written (ACCUM) or accepted (DRAIN), the FSM enters DONE; DONE asserts done_o for one cycle and returns to IDLE.
REQ-028 Addresses shall wrap modulo 128 (base 120, 16 rows covers 120..127, then 0..7).
REQ-029 mmu_valid_i outside ACCUM and out_ready_i outside DRAIN shall be ignored.
REQ-030 Outside ACCUM and DRAIN, all enables, add_o and out_valid_o shall be 0, rd_mode_o=NORMAL, and addresses shall be 0.

Reset
REQ-031 rst_i=1 shall immediately force IDLE, count 0, all registered command fields 0, and done_o=0, including mid-command; the partial command is abandoned.
REQ-032 The first command is accepted on the first rising edge after rst_i deasserts.

Configuration
REQ-033 Macro ACC_CTRL_DIAG_DRAIN_EN defined: DRAIN drives rd_mode_o to the diagonal mode, and the drain row count is num_rows + 31, up to 159, which flushes the 32-column skew.
REQ-034 Macro ACC_CTRL_DIAG_DRAIN_EN undefined: rd_mode_o is always NORMAL, and the drain row count equals num_rows.

Verification
REQ-035 Reset, then ACCUM with base=5, rows=3, overwrite=1, and 3 mmu_valid pulses -> writes to 5, 6, 7 with rd_en=0, then done_o for 1 cycle, then busy_o=0.
REQ-036 ACCUM with overwrite=0, base=0, rows=2 -> rd_en=1, add_o=1 and addr_rd=addr_wr=0, then 1, each in its write cycle.
REQ-037 DRAIN with base=126, rows=4, and out_ready low on the 2nd cycle -> addr_rd sequence 126, 127, 127, 0, 1; done_o after the 4th accept.
REQ-038 start_i pulsed during ACCUM, and mmu_valid_i during DRAIN -> no change to counters, addresses or outputs.
REQ-039 rst_i asserted mid-DRAIN at count=2 -> outputs 0 and busy_o=0 immediately; the next DRAIN restarts at base.
REQ-040 With ACC_CTRL_DIAG_DRAIN_EN, DRAIN with rows=1 -> rd_mode_o is diagonal for 32 accepted rows, then done_o.
